// File: rtl/input_conditioner.sv
// Synchronise, debounce and optionally latch board keys and switches.
// Optional sticky press latching: define INPUT_STICKY_PRESS_EN.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw_raw,
  input  logic [15:0] addr,
  input  logic        oe_cpu,
  output logic [3:0]  buttons,
  output logic [9:0]  switches,
  output logic [3:0]  press_evt
);

  localparam int unsigned N = 14;

  // Keys idle released (1), switches idle off (0).
  localparam logic [N-1:0] RST_V = {10'b0, 4'hF};

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     raw;
  logic [N-1:0]     sync1_q;
  logic [N-1:0]     sync2_q;
  logic [N-1:0]     stab_q;
  logic [N-1:0]     stab_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [3:0]       pe_q;
  logic [3:0]       pe_d;

  assign raw = {sw_raw, key_n};

  // Two-flop synchroniser for every raw pin.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= RST_V;
      sync2_q <= RST_V;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept a level after it holds for the full count.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = '0;
      stab_d[i] = stab_q[i];
      if (sync2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stab_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counters and accepted levels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stab_q <= RST_V;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stab_q <= stab_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A press is the accepted key level falling 1->0.
  always_comb begin
    pe_d = stab_q[3:0] & ~stab_d[3:0];
  end

  // Press pulse lines up with the first cycle buttons shows it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pe_q <= '0;
    end else begin
      pe_q <= pe_d;
    end
  end

  assign press_evt = pe_q;
  assign switches  = stab_q[N-1:4];

`ifdef INPUT_STICKY_PRESS_EN

  logic       rd_btn;
  logic [3:0] st_q;
  logic [3:0] st_d;
  logic [3:0] btn_q;
  logic [3:0] btn_d;

  // Sticky set dominates the read-clear in the same cycle.
  always_comb begin
    rd_btn = (addr == 16'hFFFD) && !oe_cpu;
    st_d   = (st_q & ~{4{rd_btn}}) | pe_q;
    btn_d  = ~st_d & stab_d[3:0];
  end

  // Sticky bits and a registered copy of the button view.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q  <= '0;
      btn_q <= 4'hF;
    end else begin
      st_q  <= st_d;
      btn_q <= btn_d;
    end
  end

  assign buttons = btn_q;

`else

  logic unused_bus;
  assign unused_bus = ^{addr, oe_cpu};

  assign buttons = stab_q[3:0];

`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised scoreboard bench for input_conditioner.
// Reference model works on the sampled input history.
module tb_input_conditioner;

  localparam int D = 4;
  localparam logic [13:0] RV = {10'b0, 4'hF};

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw_raw;
  logic [15:0] addr;
  logic        oe_cpu;
  logic [3:0]  buttons;
  logic [9:0]  switches;
  logic [3:0]  press_evt;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw_raw(sw_raw),
    .addr(addr),
    .oe_cpu(oe_cpu),
    .buttons(buttons),
    .switches(switches),
    .press_evt(press_evt)
  );

  typedef struct packed {
    logic [3:0] btn;
    logic [9:0] sw;
    logic [3:0] pe;
  } exp_t;

  exp_t        expq[$];
  logic [13:0] hist[$];
  logic [13:0] mq;
  logic [3:0]  mpe;
  logic [3:0]  mst;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n,
                     input logic [9:0] act,
                     input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h",
               n, $time, act, exp);
    end
  endtask

  // Reference: a bit flips once its input, seen two edges late,
  // has held the opposite level for D consecutive edges.
  always @(posedge clk) begin : model
    logic [13:0] x;
    logic [13:0] nq;
    logic [3:0]  npe;
    logic [3:0]  nst;
    logic        rd;
    logic        flip;
    int          k;
    exp_t        e;
    if (!reset) begin
      hist.delete();
      for (int r = 0; r < D + 2; r++) hist.push_back(RV);
      nq  = RV;
      npe = '0;
      nst = '0;
    end else begin
      x = {sw_raw, key_n};
      hist.push_back(x);
      if (hist.size() > 32) void'(hist.pop_front());
      nq = mq;
      for (int b = 0; b < 14; b++) begin
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
          k = hist.size() - 1 - j;
          if (k < 0) flip = 1'b0;
          else if (hist[k][b] == mq[b]) flip = 1'b0;
        end
        if (flip) nq[b] = ~mq[b];
      end
      npe = mq[3:0] & ~nq[3:0];
      rd  = (addr == 16'hFFFD) && !oe_cpu;
      nst = (mst & ~{4{rd}}) | mpe;
    end
    mq  = nq;
    mpe = npe;
    mst = nst;
`ifdef INPUT_STICKY_PRESS_EN
    e.btn = ~mst & mq[3:0];
`else
    e.btn = mq[3:0];
`endif
    e.sw = mq[13:4];
    e.pe = mpe;
    expq.push_back(e);
  end

  // Monitor: compare every registered output once per cycle.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: got 0 expected 1",
               $time);
    end else begin
      e = expq.pop_front();
      chk("buttons", {6'b0, buttons}, {6'b0, e.btn});
      chk("switches", switches, e.sw);
      chk("press_evt", {6'b0, press_evt}, {6'b0, e.pe});
    end
  end

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    key_n  = 4'h0;
    sw_raw = 10'h3FF;
    addr   = 16'h0;
    oe_cpu = 1'b0;

    // Reset values while inputs are already active.
    for (int i = 0; i < 3; i++) begin
      edge_n(1);
      chk("rst_buttons", {6'b0, buttons}, 10'h00F);
      chk("rst_switches", switches, 10'h000);
      chk("rst_press", {6'b0, press_evt}, 10'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    edge_n(5);
    chk("rel5_buttons", {6'b0, buttons}, 10'h00F);
    edge_n(1);
    chk("rel6_buttons", {6'b0, buttons}, 10'h000);
    chk("rel6_switches", switches, 10'h3FF);
    chk("rel6_press", {6'b0, press_evt}, 10'h00F);
    edge_n(1);
    chk("rel7_press", {6'b0, press_evt}, 10'h000);

    // Release all, clear any latched presses.
    @(negedge clk);
    key_n  = 4'hF;
    sw_raw = 10'h000;
    idle(10);
    addr = 16'hFFFD;
    idle(1);
    addr = 16'h0;
    idle(3);

    // Clean press on key 2.
    key_n[2] = 1'b0;
    edge_n(5);
    chk("press5_buttons", {6'b0, buttons}, 10'h00F);
    edge_n(1);
    chk("press6_buttons", {6'b0, buttons}, 10'h00B);
    chk("press6_evt", {6'b0, press_evt}, 10'h004);
    edge_n(1);
    chk("press7_evt", {6'b0, press_evt}, 10'h000);
    @(negedge clk);
    key_n[2] = 1'b1;
    idle(10);

    // Bounce on switch 5, then a clean hold.
    for (int p = 0; p < 4; p++) begin
      sw_raw[5] = ~p[0];
      idle(3);
    end
    sw_raw[5] = 1'b1;
    idle(12);

    // Short glitch on key 0.
    key_n[0] = 1'b0;
    idle(2);
    key_n[0] = 1'b1;
    idle(10);

`ifdef INPUT_STICKY_PRESS_EN
    // Press then release key 1; latched until a load.
    key_n[1] = 1'b0;
    idle(8);
    key_n[1] = 1'b1;
    idle(8);
    #1;
    chk("sticky_held", {9'b0, buttons[1]}, 10'h000);
    @(negedge clk);
    oe_cpu = 1'b1;
    addr   = 16'hFFFD;
    idle(1);
    addr   = 16'h0;
    oe_cpu = 1'b0;
    #1;
    chk("sticky_store", {9'b0, buttons[1]}, 10'h000);
    @(negedge clk);
    addr = 16'hFFFD;
    idle(1);
    addr = 16'h0;
    #1;
    chk("sticky_load", {9'b0, buttons[1]}, 10'h001);

    // Press on key 3 coinciding with a load.
    @(negedge clk);
    key_n[3] = 1'b0;
    idle(6);
    addr = 16'hFFFD;
    idle(1);
    addr     = 16'h0;
    key_n[3] = 1'b1;
    idle(8);
    #1;
    chk("setwins_held", {9'b0, buttons[3]}, 10'h000);
    @(negedge clk);
    addr = 16'hFFFD;
    idle(1);
    addr = 16'h0;
    idle(3);
`endif

    // Randomised traffic with rare resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0)
        sw_raw[$urandom_range(9)] ^= 1'b1;
      if ($urandom_range(9) == 0)
        key_n[$urandom_range(3)] ^= 1'b1;
      addr   = ($urandom_range(3) == 0) ? 16'hFFFD
                                        : 16'($urandom);
      oe_cpu = 1'($urandom_range(1));
      reset  = ($urandom_range(299) != 0);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the board's raw push-buttons and slide switches. It synchronises, debounces and optionally latches them, then drives the `buttons` and `switches` inputs of the I/O manager. Both outputs are registered and glitch-free, so a CPU load from the switch address (0xFFFC) or button address (0xFFFD) always sees a stable value. It sits between the FPGA pins and the I/O manager. It observes the CPU address bus only to clear latched presses.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable cycles required to accept a new level (1 ms at 50 MHz). Legal range 2..65535.
- `CNT_W`, default 16: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`, in, 1: single system clock. All flops are rising-edge.
- `reset`, in, 1: synchronous, active-low. `reset`=0 at a rising edge resets the block.
- `key_n`, in, 4: raw board keys, asynchronous, active-low (0 = pressed).
- `sw_raw`, in, 10: raw slide switches, asynchronous, active-high.
- `addr`, in, 16: CPU data address, the same bus that feeds the I/O manager.
- `oe_cpu`, in, 1: CPU drive enable. 1 = store, 0 = load.
- `buttons`, out, 4: conditioned keys, active-low, to the I/O manager `buttons` input.
- `switches`, out, 10: conditioned switches, to the I/O manager `switches` input.
- `press_evt`, out, 4: one-cycle pulse per key on each accepted press.

## Operation
- **Synchroniser.** Each of the 14 inputs passes through a 2-flop synchroniser. Only the second flop (`s`) is used downstream.
- **Debouncer.** There is one independent debouncer per bit: a `CNT_W`-bit counter `cnt` and a stable register `q`.
  - If `s == q`: `cnt` is set to 0.
  - If `s != q` and `cnt == DEBOUNCE_CYCLES-1`: `q` is set to `s` and `cnt` to 0.
  - If `s != q` otherwise: `cnt` is incremented by 1.
  - Any bounce back to `q` before the count completes restarts the count from 0.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- **Press edge.** For key bit i, a press is accepted on the cycle where `q_key[i]` goes 1→0. `press_evt[i]` is 1 for exactly that one cycle. A release (0→1) produces no event.
- **Switches.** `switches` = `q_sw` (registered).
- **Buttons.** `buttons` = `q_key` (registered), unless the Configuration feature is compiled in.
- **Reset values.** All four key chains reset to released: sync flops = 1, `q_key` = 1, so `buttons` = 4'b1111. Switch chains reset to 0, so `switches` = 10'b0. All counters reset to 0, `press_evt` = 0, and sticky bits are cleared (`buttons` = 4'b1111).
- **Reset mid-count.** Asserting reset during a count discards the partial count. The next level change is counted from 0 after reset releases.
- **Settled inputs at reset release.** If an input already differs from its reset value when reset releases, it takes 2 + `DEBOUNCE_CYCLES` cycles to appear. For a key held down, this also produces one `press_evt`.

## Timing
- **Latency.** An input change that holds clean settles at the output 2 + `DEBOUNCE_CYCLES` rising edges after it is first sampled (2 synchroniser edges plus `DEBOUNCE_CYCLES` counting edges). `press_evt` is asserted in the same cycle that `buttons` first shows the press.
- **Rejection.** A pulse shorter than `DEBOUNCE_CYCLES` cycles at `s` never reaches the outputs.
- **Outputs.** All outputs change only on rising edges of `clk`. There is no combinational path from any input to any output.
- **Read strobe.** `rd_btn` = (`addr` == 16'hFFFD) & ~`oe_cpu`, sampled at the rising edge. This is the CPU's single-cycle load of the button address.

## Configuration
- **Macro `INPUT_STICKY_PRESS_EN` defined:**
  - Each key has a sticky bit `st[i]`.
  - `press_evt[i]` sets `st[i]`.
  - `rd_btn` clears all `st` bits at the end of the read cycle, so the CPU reads the latched value first.
  - If a press and `rd_btn` occur in the same cycle, set wins and the bit stays 1.
  - `buttons[i]` = ~`st[i]` & `q_key[i]`. A press is therefore visible until read, even if the key was released before the read.
  - A store to 0xFFFD (`oe_cpu` = 1) does not clear the sticky bits.
- **Macro undefined:**
  - No sticky logic is present, and `addr`/`oe_cpu` are unused.
  - `buttons` = `q_key`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
1. **Reset values.** Hold `reset`=0 for 3 cycles with `key_n`=4'b0000 and `sw_raw`=10'h3FF → during reset `buttons`=4'b1111, `switches`=0, `press_evt`=0. After release, 6 cycles later: `buttons`=4'b0000, `switches`=10'h3FF, and `press_evt`=4'b1111 for one cycle.
2. **Clean press.** `key_n[2]` goes 1→0 and is held → `buttons`=4'b1011 exactly 6 edges later, with `press_evt`=4'b0100 for one cycle only.
3. **Bounce rejection.** Toggle `sw_raw[5]` 1,0,1,0 with 3-cycle pulses, then hold 1 → `switches[5]` stays 0 through the bounce and becomes 1 six edges after the final hold begins.
4. **Short glitch.** A 2-cycle low pulse on `key_n[0]` → no change on `buttons`, no `press_evt`.
5. **Sticky latch (`INPUT_STICKY_PRESS_EN`).**
   - Press and then release `key_n[1]`, both accepted → `buttons[1]` stays 0 after the release.
   - Load from 0xFFFD (`addr`=16'hFFFD, `oe_cpu`=0) for 1 cycle → `buttons[1]` returns to 1 on the next edge.
   - Store to 0xFFFD (`oe_cpu`=1) instead → `buttons[1]` stays 0.
6. **Simultaneous set/clear (`INPUT_STICKY_PRESS_EN`).** A `press_evt[3]` in the same cycle as `rd_btn` → `buttons[3]`=0 after the edge, and it clears only on the next read.
